// File: rtl/l2_arbiter.sv
// rtl/l2_arbiter.sv - two-port L1-to-L2 miss arbiter with alternating tie break
module l2_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  read_a,
  input  logic [ADDR_WIDTH-1:0] address_a,
  output logic [LINE_WIDTH-1:0] rdata_a,
  output logic                  resp_a,
  input  logic                  read_b,
  input  logic                  write_b,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [LINE_WIDTH-1:0] wdata_b,
  output logic [LINE_WIDTH-1:0] rdata_b,
  output logic                  resp_b,
  output logic                  stall_cache2_miss,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_A = 2'd1;
  localparam logic [1:0] SERVE_B = 2'd2;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_WIDTH-1:0] rdata_a_q, rdata_b_q;
  logic                  req_a, req_b;
  logic                  grant_a, grant_b;

  // Grant only from IDLE; a tie goes to whichever port did not win last time
  always_comb begin
    req_a   = read_a;
    req_b   = read_b | write_b;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == IDLE) begin
      grant_b = req_b & (!req_a | (last_grant_q == GRANT_A));
      grant_a = req_a & !grant_b;
    end
  end

  // Completion is same-cycle: response, returned line and stall release follow mem_resp
  always_comb begin
    resp_a            = (state_q == SERVE_A) & mem_resp;
    resp_b            = (state_q == SERVE_B) & mem_resp;
    stall_cache2_miss = (state_q == SERVE_B) & !mem_resp;
    rdata_a           = resp_a ? mem_rdata : rdata_a_q;
    rdata_b           = (resp_b && !mem_write_q) ? mem_rdata : rdata_b_q;
    mem_read          = mem_read_q;
    mem_write         = mem_write_q;
    mem_address       = mem_address_q;
    mem_wdata         = mem_wdata_q;
  end

  // Next state: latch the winner's request at grant, release the L2 channel on mem_resp
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_b) begin
          state_d       = SERVE_B;
          last_grant_d  = GRANT_B;
          mem_read_d    = !write_b;
          mem_write_d   = write_b;
          mem_address_d = address_b;
          mem_wdata_d   = wdata_b;
        end else if (grant_a) begin
          state_d       = SERVE_A;
          last_grant_d  = GRANT_A;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = address_a;
        end
      end
      SERVE_A, SERVE_B: begin
        if (mem_resp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and L2-side registers; reset drops strobes immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_grant_q  <= GRANT_A;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  // Returned lines are held between responses; writebacks leave rdata_b alone
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (resp_a) begin
        rdata_a_q <= mem_rdata;
      end
      if (resp_b && !mem_write_q) begin
        rdata_b_q <= mem_rdata;
      end
    end
  end

endmodule
